// File: rtl/l2_pri_bank_arb.sv
// rtl/l2_pri_bank_arb.sv - round-robin arbiter sharing one private L2 SRAM bank among N_REQ requesters
// Optional macro PMS_L2_PRI_ARB_PRIO0_EN: requester 0 gets strict priority, the rest round-robin.
module l2_pri_bank_arb #(
    parameter int          N_REQ      = 4,
    parameter int          BANK_WORDS = 8192,
    parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000,
    parameter int          IDX_W      = $clog2(BANK_WORDS)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ-1:0]            we_i,
    input  logic [N_REQ-1:0][31:0]      addr_i,
    input  logic [N_REQ-1:0][3:0]       be_i,
    input  logic [N_REQ-1:0][31:0]      wdata_i,
    output logic [N_REQ-1:0]            gnt_o,
    output logic [N_REQ-1:0]            rvalid_o,
    output logic [31:0]                 rdata_o,
    output logic                        err_o,
    output logic                        bank_req_o,
    output logic                        bank_we_o,
    output logic [IDX_W-1:0]            bank_idx_o,
    output logic [3:0]                  bank_be_o,
    output logic [31:0]                 bank_wdata_o,
    input  logic [31:0]                 bank_rdata_i
);

    localparam int              PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [32:0]     WIN_BYTES = 33'(BANK_WORDS) * 33'd4;
    localparam logic [PTR_W:0]  N_EXT     = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W:0]  N_M1      = (PTR_W+1)'(N_REQ - 1);
    localparam logic [31:0]     ERR_DATA  = 32'hBADA_CCE5;

    logic [PTR_W-1:0] rr_q, rr_d;
    logic [PTR_W-1:0] winner;
    logic             any_gnt;
    logic [PTR_W:0]   cand;
    logic [31:0]      sel_addr;
    logic [31:0]      off;
    logic             in_range;

    logic             rsp_valid_q;
    logic [PTR_W-1:0] rsp_id_q;
    logic             rsp_err_q;
    logic             rsp_we_q;
    logic             rsp_live;

    // Winner search starts at rr_q and wraps; reset masks every grant.
    always_comb begin
        winner  = '0;
        any_gnt = 1'b0;
        cand    = '0;
`ifdef PMS_L2_PRI_ARB_PRIO0_EN
        if (req_i[0]) begin
            any_gnt = 1'b1;
        end else begin
            for (int i = 0; i < N_REQ - 1; i++) begin
                cand = {1'b0, (rr_q == '0) ? PTR_W'(1) : rr_q} + (PTR_W+1)'(i);
                if (cand >= N_EXT) cand = cand - N_M1;
                if (!any_gnt && req_i[cand[PTR_W-1:0]]) begin
                    any_gnt = 1'b1;
                    winner  = cand[PTR_W-1:0];
                end
            end
        end
`else
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_q} + (PTR_W+1)'(i);
            if (cand >= N_EXT) cand = cand - N_EXT;
            if (!any_gnt && req_i[cand[PTR_W-1:0]]) begin
                any_gnt = 1'b1;
                winner  = cand[PTR_W-1:0];
            end
        end
`endif
        if (rst_i) any_gnt = 1'b0;
    end

    always_comb begin
        sel_addr = addr_i[winner];
        off      = sel_addr - BASE_ADDR;
        in_range = (sel_addr >= BASE_ADDR) && ({1'b0, off} < WIN_BYTES);
    end

    always_comb begin
        rr_d = rr_q;
`ifdef PMS_L2_PRI_ARB_PRIO0_EN
        if (any_gnt && winner != '0) begin
`else
        if (any_gnt) begin
`endif
            rr_d = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + PTR_W'(1);
        end
    end

    always_comb begin
        gnt_o        = any_gnt ? (N_REQ'(1) << winner) : '0;
        bank_req_o   = any_gnt && in_range;
        bank_we_o    = bank_req_o && we_i[winner];
        bank_idx_o   = bank_req_o ? off[IDX_W+1:2] : '0;
        bank_be_o    = bank_req_o ? be_i[winner] : '0;
        bank_wdata_o = bank_req_o ? wdata_i[winner] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            rsp_we_q    <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            rsp_valid_q <= any_gnt;
            if (any_gnt) begin
                rsp_id_q  <= winner;
                rsp_err_q <= !in_range;
                rsp_we_q  <= we_i[winner];
            end
        end
    end

    // A response still registered when reset arrives is dropped, not delivered.
    always_comb begin
        rsp_live = rsp_valid_q && !rst_i;
        rvalid_o = rsp_live ? (N_REQ'(1) << rsp_id_q) : '0;
        err_o    = rsp_live && rsp_err_q;
        if (!rsp_live)     rdata_o = '0;
        else if (rsp_err_q) rdata_o = ERR_DATA;
        else if (rsp_we_q)  rdata_o = '0;
        else                rdata_o = bank_rdata_i;
    end

endmodule

// File: tb/tb_l2_pri_bank_arb.sv
// tb/tb_l2_pri_bank_arb.sv - directed and randomized bench for l2_pri_bank_arb with a behavioural reference model
// Honours PMS_L2_PRI_ARB_PRIO0_EN when defined for the build.
module tb_l2_pri_bank_arb;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h1C00_0000;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [N-1:0]       req_i;
    logic [N-1:0]       we_i;
    logic [N-1:0][31:0] addr_i;
    logic [N-1:0][3:0]  be_i;
    logic [N-1:0][31:0] wdata_i;
    logic [N-1:0]       gnt_o;
    logic [N-1:0]       rvalid_o;
    logic [31:0]        rdata_o;
    logic               err_o;
    logic               bank_req_o;
    logic               bank_we_o;
    logic [12:0]        bank_idx_o;
    logic [3:0]         bank_be_o;
    logic [31:0]        bank_wdata_o;
    logic [31:0]        bank_rdata_i = 32'h0;

    l2_pri_bank_arb #(.N_REQ(N), .BANK_WORDS(8192), .BASE_ADDR(BASE)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .bank_req_o(bank_req_o), .bank_we_o(bank_we_o),
        .bank_idx_o(bank_idx_o), .bank_be_o(bank_be_o), .bank_wdata_o(bank_wdata_o),
        .bank_rdata_i(bank_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // SRAM macro stand-in: one-cycle read latency, byte-lane writes.
    logic [31:0] sram [0:8191];
    initial for (int i = 0; i < 8192; i++) sram[i] = 32'h0;
    always @(posedge clk_i) begin
        if (bank_req_o) begin
            if (bank_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bank_be_o[b]) sram[bank_idx_o][b*8 +: 8] <= bank_wdata_o[b*8 +: 8];
            end else begin
                bank_rdata_i <= sram[bank_idx_o];
            end
        end
    end

    int          total = 0;
    int          passed = 0;
    bit          auto_clear = 1'b1;
    int          last_w = -1;
    int          m_rr = 0;
    bit          m_pv = 1'b0;
    int          m_pid = 0;
    bit          m_perr = 1'b0;
    bit          m_pwe = 1'b0;
    logic [31:0] m_pdata = 32'h0;
    logic [31:0] m_mem [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int pick();
        int start;
`ifdef PMS_L2_PRI_ARB_PRIO0_EN
        if (req_i[0]) return 0;
        start = (m_rr == 0) ? 1 : m_rr;
        for (int k = 0; k < N - 1; k++) begin
            int c = 1 + ((start - 1 + k) % (N - 1));
            if (req_i[c]) return c;
        end
`else
        start = m_rr;
        for (int k = 0; k < N; k++) begin
            int c = (start + k) % N;
            if (req_i[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic eval_cycle();
        int          w;
        int          idx;
        bit          inr;
        bit          live;
        logic [31:0] a;
        logic [31:0] off;
        logic [31:0] exp_rd;
        logic [31:0] word;
        @(negedge clk_i);
        live   = m_pv && !rst_i;
        exp_rd = !live ? 32'h0 : m_perr ? 32'hBADACCE5 : m_pwe ? 32'h0 : m_pdata;
        check("rvalid", 32'(rvalid_o), live ? (32'(1) << m_pid) : 32'h0);
        check("err", 32'(err_o), 32'(live && m_perr));
        check("rdata", rdata_o, exp_rd);
        w = rst_i ? -1 : pick();
        check("gnt", 32'(gnt_o), (w < 0) ? 32'h0 : (32'(1) << w));
        inr = 1'b0;
        idx = 0;
        if (w >= 0) begin
            a   = addr_i[w];
            off = a - BASE;
            inr = (a >= BASE) && (off < 32'd32768);
            idx = int'(off >> 2);
        end
        check("bank_req", 32'(bank_req_o), 32'(inr));
        if (inr) begin
            check("bank_idx", 32'(bank_idx_o), 32'(idx));
            check("bank_we", 32'(bank_we_o), 32'(we_i[w]));
            if (we_i[w]) begin
                check("bank_be", 32'(bank_be_o), 32'(be_i[w]));
                check("bank_wdata", bank_wdata_o, wdata_i[w]);
            end
        end
        if (rst_i) begin
            m_rr = 0;
            m_pv = 1'b0;
        end else if (w < 0) begin
            m_pv = 1'b0;
        end else begin
            m_pv   = 1'b1;
            m_pid  = w;
            m_perr = !inr;
            m_pwe  = we_i[w];
            if (inr) begin
                word = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
                if (we_i[w]) begin
                    for (int b = 0; b < 4; b++)
                        if (be_i[w][b]) word[b*8 +: 8] = wdata_i[w][b*8 +: 8];
                    m_mem[idx] = word;
                end else begin
                    m_pdata = word;
                end
            end
`ifdef PMS_L2_PRI_ARB_PRIO0_EN
            if (w != 0) m_rr = (w + 1) % N;
`else
            m_rr = (w + 1) % N;
`endif
        end
        last_w = w;
    endtask

    task automatic next_edge();
        @(posedge clk_i);
        #1;
        if (auto_clear && last_w >= 0) req_i[last_w] = 1'b0;
    endtask

    task automatic step();
        eval_cycle();
        next_edge();
    endtask

    task automatic set_req(input int k, input bit we, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] d);
        req_i[k]   = 1'b1;
        we_i[k]    = we;
        addr_i[k]  = a;
        be_i[k]    = be;
        wdata_i[k] = d;
    endtask

    function automatic logic [31:0] rand_addr();
        int r = int'($urandom_range(7, 0));
        if (r < 6) return BASE + 32'(4 * $urandom_range(15, 0)) + 32'($urandom_range(3, 0));
        if (r == 6) return BASE + 32'h7FFC;
        if ($urandom_range(1, 0) == 1) return BASE + 32'h8000 + 32'(4 * $urandom_range(63, 0));
        return BASE - 32'h4 - 32'(4 * $urandom_range(63, 0));
    endfunction

    initial begin
        req_i = '0; we_i = '0; addr_i = '0; be_i = '0; wdata_i = '0;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        req_i = 4'b1111;
        eval_cycle();
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_breq", 32'(bank_req_o), 32'h0);
        next_edge();
        req_i = '0;
        step();
        rst_i = 1'b0;

        set_req(2, 1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF);
        eval_cycle();
        check("wr_gnt", 32'(gnt_o), 32'h4);
        check("wr_idx", 32'(bank_idx_o), 32'd4);
        next_edge();
        set_req(2, 1'b0, BASE + 32'h10, 4'hF, 32'h0);
        eval_cycle();
        check("rd_gnt", 32'(gnt_o), 32'h4);
        check("rd_idx", 32'(bank_idx_o), 32'd4);
        next_edge();
        eval_cycle();
        check("rd_rvalid", 32'(rvalid_o), 32'h4);
        check("rd_data", rdata_o, 32'hDEADBEEF);
        check("rd_err", 32'(err_o), 32'h0);
        next_edge();

        set_req(1, 1'b0, 32'h1C00_8000, 4'hF, 32'h0);
        eval_cycle();
        check("oor_hi_gnt", 32'(gnt_o), 32'h2);
        check("oor_hi_breq", 32'(bank_req_o), 32'h0);
        next_edge();
        eval_cycle();
        check("oor_hi_err", 32'(err_o), 32'h1);
        check("oor_hi_data", rdata_o, 32'hBADACCE5);
        next_edge();
        set_req(3, 1'b0, 32'h1BFF_FFFC, 4'hF, 32'h0);
        step();
        eval_cycle();
        check("oor_lo_err", 32'(err_o), 32'h1);
        check("oor_lo_rvalid", 32'(rvalid_o), 32'h8);
        next_edge();

        set_req(0, 1'b0, 32'h1C00_7FFC, 4'hF, 32'h0);
        eval_cycle();
        check("bnd_idx", 32'(bank_idx_o), 32'd8191);
        check("bnd_breq", 32'(bank_req_o), 32'h1);
        next_edge();
        eval_cycle();
        check("bnd_err", 32'(err_o), 32'h0);
        next_edge();

        set_req(1, 1'b1, BASE + 32'h20, 4'hF, 32'hAABBCCDD);
        step();
        set_req(1, 1'b1, BASE + 32'h20, 4'b0011, 32'h11223344);
        step();
        set_req(1, 1'b0, BASE + 32'h20, 4'hF, 32'h0);
        step();
        eval_cycle();
        check("be_merge", rdata_o, 32'hAABB3344);
        next_edge();

        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        auto_clear = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, 1'b0, BASE + 32'(4 * k), 4'hF, 32'h0);
        for (int c = 0; c < 8; c++) begin
            eval_cycle();
`ifdef PMS_L2_PRI_ARB_PRIO0_EN
            check("rr_order", 32'(gnt_o), 32'h1);
`else
            check("rr_order", 32'(gnt_o), 32'(1) << (c % N));
`endif
            next_edge();
        end
        req_i = '0;
        auto_clear = 1'b1;
        step();

        set_req(1, 1'b0, BASE + 32'h8, 4'hF, 32'h0);
        eval_cycle();
        check("mid_gnt", 32'(gnt_o), 32'h2);
        next_edge();
        rst_i = 1'b1;
        eval_cycle();
        check("mid_drop", 32'(rvalid_o), 32'h0);
        next_edge();
        rst_i = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, 1'b0, BASE + 32'(4 * k), 4'hF, 32'h0);
        eval_cycle();
        check("mid_first", 32'(gnt_o), 32'h1);
        next_edge();

        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!req_i[k] && $urandom_range(1, 0) == 1)
                    set_req(k, 1'($urandom_range(1, 0)), rand_addr(), 4'($urandom_range(15, 0)), $urandom);
            end
            rst_i = ($urandom_range(49, 0) == 0);
            step();
        end
        rst_i = 1'b0;
        req_i = '0;
        step();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
